// File: rtl/banco_de_registradores_param_pkg.sv
// Shared types and helpers for the parametrised register bank.
// Clear-engine state encoding and a constant-safe ceil(log2) function.
package banco_de_registradores_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_e;

    // ceil(log2(n)), never less than 1 so a 2-entry bank still gets an address bit
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/banco_de_registradores_param_clear_seq.sv
// Bulk-clear sequencer: walks every register index once after a request.
// Ports: clear_i request in; clr_en_o/clr_idx_o drive storage; busy_o, done_o status.
module banco_de_registradores_param_clear_seq
    import banco_de_registradores_param_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          Clock_in,
    input  logic          Signal_reset_n,
    input  logic          clear_i,
    output logic          clr_en_o,
    output logic [AW-1:0] clr_idx_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    clr_state_e    state_q;
    logic [AW-1:0] idx_q;
    logic          busy_q;
    logic          done_q;

    // Busy spans CLEAR and DONE; done pulses during the single DONE cycle
    always_ff @(posedge Clock_in or negedge Signal_reset_n) begin
        if (!Signal_reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clear_i) begin
                        state_q <= ST_CLEAR;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (idx_q == LAST) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_en_o  = (state_q == ST_CLEAR);
    assign clr_idx_o = idx_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: rtl/banco_de_registradores_param.sv
// DEPTH x DATA_W register bank: NUM_RD registered read ports, byte-enabled write,
// write-first bypass, optional zero register and a sequenced bulk clear.
module banco_de_registradores_param
    import banco_de_registradores_param_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int DEPTH    = 16,
    parameter  int NUM_RD   = 2,
    parameter  int ZERO_REG = 0,
    parameter  int ONE_IDX  = 1,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic                     Clock_in,
    input  logic                     Signal_reset_n,
    input  logic [NUM_RD*AW-1:0]     Read_addr,
    input  logic                     Signal_read,
    output logic [NUM_RD*DATA_W-1:0] Out_data,
    input  logic [AW-1:0]            Address_to_write,
    input  logic [DATA_W-1:0]        Data_to_write,
    input  logic [DATA_W/8-1:0]      Write_be,
    input  logic                     Signal_write,
    input  logic                     Signal_clear,
    output logic                     Busy,
    output logic                     Clear_done,
    output logic                     Write_drop
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [NUM_RD*DATA_W-1:0] out_q, out_d;
    logic                     drop_q, drop_d;
    logic [DATA_W-1:0]        cur, merged;
    logic                     wr_ok;
    logic                     clr_en;
    logic [AW-1:0]            clr_idx;
    logic [AW-1:0]            ra;

    function automatic logic [DATA_W-1:0] rst_val(input int i);
        return (i == ONE_IDX) ? DATA_W'(1) : '0;
    endfunction

    function automatic logic in_rng(input logic [AW-1:0] a);
        return ({{(32-AW){1'b0}}, a} < 32'(DEPTH));
    endfunction

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    banco_de_registradores_param_clear_seq #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_clear (
        .Clock_in      (Clock_in),
        .Signal_reset_n(Signal_reset_n),
        .clear_i       (Signal_clear),
        .clr_en_o      (clr_en),
        .clr_idx_o     (clr_idx),
        .busy_o        (Busy),
        .done_o        (Clear_done)
    );

    // Write merge: untouched bytes keep the current contents
    always_comb begin
        cur = '0;
        if (in_rng(Address_to_write)) cur = mem_q[Address_to_write];
        merged = cur;
        for (int b = 0; b < NB; b++) begin
            if (Write_be[b]) merged[8*b +: 8] = Data_to_write[8*b +: 8];
        end
        wr_ok = Signal_write && !Busy
                && in_rng(Address_to_write)
                && !is_zero(Address_to_write);
        drop_d = Signal_write && !wr_ok;
    end

    // Read muxes with write-first bypass; the clear engine is never bypassed
    always_comb begin
        out_d = out_q;
        ra    = '0;
        if (Signal_read) begin
            for (int k = 0; k < NUM_RD; k++) begin
                ra = Read_addr[k*AW +: AW];
                if (!in_rng(ra) || is_zero(ra))
                    out_d[k*DATA_W +: DATA_W] = '0;
                else if (wr_ok && ra == Address_to_write)
                    out_d[k*DATA_W +: DATA_W] = merged;
                else
                    out_d[k*DATA_W +: DATA_W] = mem_q[ra];
            end
        end
    end

    // Clear and write never collide: a write is only accepted while not busy
    always_ff @(posedge Clock_in or negedge Signal_reset_n) begin
        if (!Signal_reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= rst_val(i);
        end else if (clr_en) begin
            mem_q[clr_idx] <= rst_val(int'(clr_idx));
        end else if (wr_ok) begin
            mem_q[Address_to_write] <= merged;
        end
    end

    always_ff @(posedge Clock_in or negedge Signal_reset_n) begin
        if (!Signal_reset_n) begin
            out_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            drop_q <= drop_d;
        end
    end

    assign Out_data   = out_q;
    assign Write_drop = drop_q;

endmodule

// File: tb/tb_banco_de_registradores_param.sv
// Bench for banco_de_registradores_param: default bank plus a 12-entry zero-reg bank
// driven by the same stimulus and compared against an array-based reference model.
module tb_banco_de_registradores_param;

    logic        clk;
    logic        rst_n;
    logic [7:0]  raddr;
    logic        rd;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic        clr;
    logic [63:0] out0, out1;
    logic        busy0, busy1, done0, done1, drop0, drop1;

    int checks;
    int failures;

    banco_de_registradores_param dut0 (
        .Clock_in        (clk),
        .Signal_reset_n  (rst_n),
        .Read_addr       (raddr),
        .Signal_read     (rd),
        .Out_data        (out0),
        .Address_to_write(waddr),
        .Data_to_write   (wdata),
        .Write_be        (be),
        .Signal_write    (we),
        .Signal_clear    (clr),
        .Busy            (busy0),
        .Clear_done      (done0),
        .Write_drop      (drop0)
    );

    banco_de_registradores_param #(
        .DEPTH   (12),
        .ZERO_REG(1)
    ) dut1 (
        .Clock_in        (clk),
        .Signal_reset_n  (rst_n),
        .Read_addr       (raddr),
        .Signal_read     (rd),
        .Out_data        (out1),
        .Address_to_write(waddr),
        .Data_to_write   (wdata),
        .Write_be        (be),
        .Signal_write    (we),
        .Signal_clear    (clr),
        .Busy            (busy1),
        .Clear_done      (done1),
        .Write_drop      (drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one register array per bank, clear walks one register per cycle
    int          D [2] = '{16, 12};
    bit          Z [2] = '{1'b0, 1'b1};
    logic [31:0] mem [2][16];
    int          cpos [2];
    logic [31:0] eo [2][2];
    bit          ebusy [2], edone [2], edrop [2];

    function automatic logic [31:0] rv(input int i);
        return (i == 1) ? 32'd1 : 32'd0;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 16; i++) mem[n][i] = rv(i);
            cpos[n]  = -1;
            eo[n][0] = '0;
            eo[n][1] = '0;
            ebusy[n] = 1'b0;
            edone[n] = 1'b0;
            edrop[n] = 1'b0;
        end
    endtask

    task automatic idle_in();
        we  = 1'b0;
        rd  = 1'b0;
        clr = 1'b0;
    endtask

    // Advance the model by one edge using the current inputs, then clock the DUTs
    task automatic cyc();
        bit   bsy, ok;
        int   a;
        for (int n = 0; n < 2; n++) begin
            bsy = (cpos[n] >= 0);
            ok  = we && !bsy && (int'(waddr) < D[n]) && !(Z[n] && waddr == 4'd0);
            edrop[n] = we && !ok;
            if (ok)
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem[n][waddr][8*b +: 8] = wdata[8*b +: 8];
            if (rd)
                for (int k = 0; k < 2; k++) begin
                    a = int'(raddr[4*k +: 4]);
                    eo[n][k] = (a >= D[n] || (Z[n] && a == 0)) ? 32'd0 : mem[n][a];
                end
            if (cpos[n] == D[n]) cpos[n] = -1;
            else if (cpos[n] >= 0) begin
                mem[n][cpos[n]] = rv(cpos[n]);
                cpos[n] = cpos[n] + 1;
            end else if (clr) cpos[n] = 0;
            ebusy[n] = (cpos[n] >= 0);
            edone[n] = (cpos[n] == D[n]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_in();
        raddr = '0; waddr = '0; wdata = '0; be = '0;
        model_reset();
        #2;
        checks++;
        if (out0 !== 64'd0 || busy0 !== 1'b0 || done0 !== 1'b0 || drop0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: out=%h busy=%b done=%b drop=%b required 0", out0, busy0, done0, drop0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd = 1'b1; raddr = {4'd1, 4'd0};
        cyc();
        rd = 1'b0;
        checks++;
        if (out0 !== {32'd1, 32'd0}) begin
            failures++;
            $display("FAIL reset_read0: got %h required %h", out0, {32'd1, 32'd0});
        end
        checks++;
        if (out1 !== {32'd1, 32'd0}) begin
            failures++;
            $display("FAIL reset_read1: got %h required %h", out1, {32'd1, 32'd0});
        end
    endtask

    task automatic test_byte_enable();
        we = 1'b1; waddr = 4'd5; wdata = 32'hDEADBEEF; be = 4'b0101;
        cyc();
        we = 1'b0;
        checks++;
        if (drop0 !== 1'b0) begin
            failures++;
            $display("FAIL be_nodrop: got %b required 0", drop0);
        end
        rd = 1'b1; raddr = {4'd5, 4'd5};
        cyc();
        rd = 1'b0;
        checks++;
        if (out0 !== {32'h00AD00EF, 32'h00AD00EF}) begin
            failures++;
            $display("FAIL be_merge: got %h required 00ad00ef x2", out0);
        end
        be = 4'b0000; we = 1'b1; wdata = 32'hFFFFFFFF; rd = 1'b1;
        cyc();
        idle_in();
        checks++;
        if (drop0 !== 1'b0 || out0[31:0] !== 32'h00AD00EF) begin
            failures++;
            $display("FAIL be_zero: drop=%b data=%h required 0 00ad00ef", drop0, out0[31:0]);
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; waddr = 4'd3; wdata = 32'h12345678; be = 4'hF;
        rd = 1'b1; raddr = {4'd0, 4'd3};
        cyc();
        idle_in();
        checks++;
        if (out0 !== {32'd0, 32'h12345678}) begin
            failures++;
            $display("FAIL bypass0: got %h required %h", out0, {32'd0, 32'h12345678});
        end
        checks++;
        if (out1[31:0] !== 32'h12345678) begin
            failures++;
            $display("FAIL bypass1: got %h required 12345678", out1[31:0]);
        end
        cyc();
        checks++;
        if (out0 !== {32'd0, 32'h12345678}) begin
            failures++;
            $display("FAIL read_hold: got %h required %h", out0, {32'd0, 32'h12345678});
        end
    endtask

    task automatic test_zero_reg();
        we = 1'b1; waddr = 4'd0; wdata = 32'hFFFFFFFF; be = 4'hF;
        rd = 1'b1; raddr = {4'd0, 4'd0};
        cyc();
        idle_in();
        checks++;
        if (drop1 !== 1'b1 || out1 !== 64'd0) begin
            failures++;
            $display("FAIL zero_reg: drop=%b out=%h required 1 0", drop1, out1);
        end
        checks++;
        if (drop0 !== 1'b0 || out0 !== {2{32'hFFFFFFFF}}) begin
            failures++;
            $display("FAIL plain_reg0: drop=%b out=%h required 0 ffffffff x2", drop0, out0);
        end
        cyc();
        checks++;
        if (drop1 !== 1'b0) begin
            failures++;
            $display("FAIL drop_pulse: got %b required 0", drop1);
        end
    endtask

    task automatic test_out_of_range();
        we = 1'b1; waddr = 4'd13; wdata = 32'h0BADF00D; be = 4'hF;
        rd = 1'b1; raddr = {4'd13, 4'd13};
        cyc();
        idle_in();
        checks++;
        if (drop1 !== 1'b1 || out1 !== 64'd0) begin
            failures++;
            $display("FAIL oor_small: drop=%b out=%h required 1 0", drop1, out1);
        end
        checks++;
        if (drop0 !== 1'b0 || out0 !== {2{32'h0BADF00D}}) begin
            failures++;
            $display("FAIL oor_big: drop=%b out=%h required 0 0badf00d x2", drop0, out0);
        end
    endtask

    task automatic test_clear();
        int b0, b1, d0, d1;
        logic [31:0] x0, x1;
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; waddr = 4'(i); wdata = $urandom | 32'h100; be = 4'hF;
            cyc();
        end
        we = 1'b0;
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        b0 = 0; b1 = 0; d0 = 0; d1 = 0;
        for (int j = 0; j < 40; j++) begin
            b0 += int'(busy0); b1 += int'(busy1);
            d0 += int'(done0); d1 += int'(done1);
            if (j == 4) begin
                we = 1'b1; waddr = 4'd2; wdata = 32'hA5A5A5A5; be = 4'hF;
                cyc();
                we = 1'b0;
                checks++;
                if (drop0 !== 1'b1 || drop1 !== 1'b1) begin
                    failures++;
                    $display("FAIL clear_wdrop: got %b%b required 11", drop0, drop1);
                end
            end else cyc();
        end
        checks++;
        if (b0 != 17 || b1 != 13) begin
            failures++;
            $display("FAIL busy_len: got %0d/%0d required 17/13", b0, b1);
        end
        checks++;
        if (d0 != 1 || d1 != 1) begin
            failures++;
            $display("FAIL done_pulse: got %0d/%0d required 1/1", d0, d1);
        end
        for (int i = 0; i < 16; i++) begin
            rd = 1'b1; raddr = {4'(i), 4'(i)};
            cyc();
            x0 = (i == 1) ? 32'd1 : 32'd0;
            x1 = (i == 1) ? 32'd1 : 32'd0;
            checks++;
            if (out0 !== {x0, x0} || out1 !== {x1, x1}) begin
                failures++;
                $display("FAIL clear_val[%0d]: got %h %h required %h %h", i, out0, out1, {x0, x0}, {x1, x1});
            end
        end
        rd = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        we = 1'b1; waddr = 4'd9; wdata = 32'hCAFEF00D; be = 4'hF;
        cyc();
        we = 1'b0;
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        repeat (7) cyc();
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0 || done0 !== 1'b0 || out0 !== 64'd0) begin
            failures++;
            $display("FAIL midclr_reset: busy=%b%b done=%b out=%h required 0", busy0, busy1, done0, out0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd = 1'b1; raddr = {4'd1, 4'd9};
        cyc();
        rd = 1'b0;
        checks++;
        if (out0 !== {32'd1, 32'd0} || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL midclr_regs: out=%h busy=%b required %h 0", out0, busy0, {32'd1, 32'd0});
        end
    endtask

    task automatic test_random();
        logic [63:0] o;
        bit bb, dd, dr;
        for (int t = 0; t < 600; t++) begin
            we    = ($urandom_range(0, 1) == 1);
            waddr = 4'($urandom_range(0, 15));
            wdata = $urandom;
            be    = 4'($urandom_range(0, 15));
            rd    = ($urandom_range(0, 9) < 7);
            raddr = 8'($urandom_range(0, 255));
            clr   = ($urandom_range(0, 59) == 0);
            cyc();
            for (int n = 0; n < 2; n++) begin
                o  = (n == 0) ? out0 : out1;
                bb = (n == 0) ? busy0 : busy1;
                dd = (n == 0) ? done0 : done1;
                dr = (n == 0) ? drop0 : drop1;
                checks++;
                if (o !== {eo[n][1], eo[n][0]}) begin
                    failures++;
                    $display("FAIL rnd_out%0d t=%0d: got %h required %h", n, t, o, {eo[n][1], eo[n][0]});
                end
                checks++;
                if (bb !== ebusy[n] || dd !== edone[n] || dr !== edrop[n]) begin
                    failures++;
                    $display("FAIL rnd_flags%0d t=%0d: got %b%b%b required %b%b%b",
                             n, t, bb, dd, dr, ebusy[n], edone[n], edrop[n]);
                end
            end
        end
        idle_in();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_byte_enable();
        test_bypass();
        test_zero_reg();
        test_out_of_range();
        test_clear();
        test_reset_mid_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
